// File: rtl/eco32f_div_ctrl_pkg.sv
// ============================================================================
// Package : eco32f_div_ctrl_pkg
// Purpose : Shared types for the EX-stage integer divide sequencer.
//           - div_state_t : sequencer states (3-bit encoding)
//           - div_kind_t  : latched operation kind
//           - helpers for operand magnitude and kind classification
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package eco32f_div_ctrl_pkg;

  typedef enum logic [2:0] {
    DIV_ST_IDLE = 3'd0,
    DIV_ST_LOAD = 3'd1,
    DIV_ST_BUSY = 3'd2,
    DIV_ST_FIX  = 3'd3,
    DIV_ST_DONE = 3'd4
  } div_state_t;

  typedef enum logic [1:0] {
    DIV_KIND_DIV  = 2'd0,
    DIV_KIND_DIVU = 2'd1,
    DIV_KIND_REM  = 2'd2,
    DIV_KIND_REMU = 2'd3
  } div_kind_t;

  function automatic logic kind_is_signed(div_kind_t k);
    return (k == DIV_KIND_DIV) || (k == DIV_KIND_REM);
  endfunction

  function automatic logic kind_is_rem(div_kind_t k);
    return (k == DIV_KIND_REM) || (k == DIV_KIND_REMU);
  endfunction

  // Magnitude of a two's-complement value when sgn is set, raw value otherwise.
  // 0x80000000 maps to itself, which is the correct unsigned magnitude 2^31.
  function automatic logic [31:0] mag32(logic [31:0] v, logic sgn);
    return (sgn && v[31]) ? (32'd0 - v) : v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/eco32f_div_step.sv
// ============================================================================
// Module  : eco32f_div_step
// Purpose : Combinational radix-2^BITS restoring divide step. Shifts BITS
//           dividend bits (MSB first) into the partial remainder, subtracting
//           the divisor whenever it fits and emitting one quotient bit each.
// Ports   : rem_in   [31:0]     partial remainder (always < divisor)
//           dvd_bits [BITS-1:0] next dividend bits, MSB first
//           divisor  [31:0]     divisor magnitude (nonzero)
//           rem_out  [31:0]     updated partial remainder
//           q_bits   [BITS-1:0] quotient bits produced this step
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module eco32f_div_step #(
  parameter int BITS = 1
) (
  input  logic [31:0]     rem_in,
  input  logic [BITS-1:0] dvd_bits,
  input  logic [31:0]     divisor,
  output logic [31:0]     rem_out,
  output logic [BITS-1:0] q_bits
);

  // partial is 33 bits: a remainder below the divisor, shifted left, can
  // reach 2*divisor-1 which overflows 32 bits.
  logic [32:0] partial;
  logic [31:0] r;

  always_comb begin
    r       = rem_in;
    partial = '0;
    q_bits  = '0;
    for (int i = BITS - 1; i >= 0; i--) begin
      partial = {r, dvd_bits[i]};
      if (partial >= {1'b0, divisor}) begin
        // Difference is below the divisor, so the low 32 bits are exact.
        r         = partial[31:0] - divisor;
        q_bits[i] = 1'b1;
      end else begin
        r = partial[31:0];
      end
    end
    rem_out = r;
  end

endmodule

`default_nettype wire

// File: rtl/eco32f_div_ctrl.sv
// ============================================================================
// Module  : eco32f_div_ctrl
// Purpose : Multi-cycle div/divu/rem/remu sequencer for the EX stage. Holds
//           the pipeline with div_stall while iterating, then presents the
//           quotient or remainder to the EX result mux.
// Ports   : clk, rst (async, active-low)
//           ex_valid, ex_op_div/divu/rem/remu, ex_x, ex_y : EX instruction
//           pipe_stall : EX held by another source (keeps result in DONE)
//           flush      : kill the EX instruction
//           div_stall, ex_div_done, ex_div_result, ex_div_by_zero : outputs
// Config  : ECO32F_DIV_EARLY_OUT_EN - when defined, |x| < |y| skips the
//           iteration and completes in 3 cycles. Results are unchanged.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module eco32f_div_ctrl
  import eco32f_div_ctrl_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_op_div,
  input  logic        ex_op_divu,
  input  logic        ex_op_rem,
  input  logic        ex_op_remu,
  input  logic [31:0] ex_x,
  input  logic [31:0] ex_y,
  input  logic        pipe_stall,
  input  logic        flush,
  output logic        div_stall,
  output logic        ex_div_done,
  output logic [31:0] ex_div_result,
  output logic        ex_div_by_zero
);

  localparam int ITER  = 32 / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(ITER);

  div_state_t        state;
  div_kind_t         kind;
  logic              q_neg;
  logic              r_neg;
  logic [31:0]       rem_q;   // partial remainder
  logic [31:0]       dvd_q;   // dividend shifts out at the top, quotient fills in below
  logic [31:0]       dvs_q;   // divisor magnitude
  logic [CNT_W-1:0]  cnt;

  // ---------------------------------------------------------------- decode
  div_kind_t op_kind;
  logic      is_op;
  logic      start;
  logic      op_signed;

  always_comb begin
    op_kind = DIV_KIND_DIV;
    if (ex_op_div)       op_kind = DIV_KIND_DIV;
    else if (ex_op_divu) op_kind = DIV_KIND_DIVU;
    else if (ex_op_rem)  op_kind = DIV_KIND_REM;
    else if (ex_op_remu) op_kind = DIV_KIND_REMU;
  end

  assign is_op     = ex_op_div | ex_op_divu | ex_op_rem | ex_op_remu;
  assign op_signed = kind_is_signed(op_kind);
  // A flush in the same cycle kills the instruction before it can start.
  assign start     = (state == DIV_ST_IDLE) & ex_valid & is_op & ~flush;

  // The hold must cover the issue cycle itself, so start feeds it directly.
  assign div_stall = start | (state == DIV_ST_LOAD) | (state == DIV_ST_BUSY)
                   | (state == DIV_ST_FIX);

  // ---------------------------------------------------------------- datapath
  logic [31:0]               step_rem;
  logic [BITS_PER_CYCLE-1:0] step_q;
  logic [31:0]               step_dvd;

  eco32f_div_step #(
    .BITS (BITS_PER_CYCLE)
  ) u_step (
    .rem_in   (rem_q),
    .dvd_bits (dvd_q[31 -: BITS_PER_CYCLE]),
    .divisor  (dvs_q),
    .rem_out  (step_rem),
    .q_bits   (step_q)
  );

  assign step_dvd = {dvd_q[31-BITS_PER_CYCLE:0], step_q};

  logic [31:0] q_fix;
  logic [31:0] r_fix;
  logic [31:0] fix_result;

  assign q_fix      = q_neg ? (32'd0 - dvd_q) : dvd_q;
  assign r_fix      = r_neg ? (32'd0 - rem_q) : rem_q;
  assign fix_result = kind_is_rem(kind) ? r_fix : q_fix;

  // ---------------------------------------------------------------- FSM
  // The first restoring step runs in LOAD, so LOAD plus BUSY together cover
  // all ITER steps and done lands ITER+2 cycles after issue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= DIV_ST_IDLE;
      kind           <= DIV_KIND_DIV;
      q_neg          <= 1'b0;
      r_neg          <= 1'b0;
      rem_q          <= '0;
      dvd_q          <= '0;
      dvs_q          <= '0;
      cnt            <= '0;
      ex_div_done    <= 1'b0;
      ex_div_result  <= '0;
      ex_div_by_zero <= 1'b0;
    end else if (flush) begin
      state          <= DIV_ST_IDLE;
      cnt            <= '0;
      ex_div_done    <= 1'b0;
      ex_div_result  <= '0;
      ex_div_by_zero <= 1'b0;
    end else begin
      case (state)
        DIV_ST_IDLE: begin
          if (start) begin
            state <= DIV_ST_LOAD;
            kind  <= op_kind;
            q_neg <= op_signed & (ex_x[31] ^ ex_y[31]);
            r_neg <= op_signed & ex_x[31];
            rem_q <= '0;
            dvd_q <= mag32(ex_x, op_signed);
            dvs_q <= mag32(ex_y, op_signed);
            cnt   <= CNT_W'(ITER - 1);
          end
        end

        DIV_ST_LOAD: begin
          if (dvs_q == 32'd0) begin
            state          <= DIV_ST_DONE;
            ex_div_done    <= 1'b1;
            ex_div_result  <= '0;
            ex_div_by_zero <= 1'b1;
          end
`ifdef ECO32F_DIV_EARLY_OUT_EN
          else if (dvd_q < dvs_q) begin
            // Quotient is zero and the whole dividend is the remainder.
            rem_q <= dvd_q;
            dvd_q <= '0;
            state <= DIV_ST_FIX;
          end
`endif
          else begin
            rem_q <= step_rem;
            dvd_q <= step_dvd;
            cnt   <= cnt - 1'b1;
            state <= DIV_ST_BUSY;
          end
        end

        DIV_ST_BUSY: begin
          rem_q <= step_rem;
          dvd_q <= step_dvd;
          if (cnt == '0) begin
            state <= DIV_ST_FIX;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        DIV_ST_FIX: begin
          state          <= DIV_ST_DONE;
          ex_div_done    <= 1'b1;
          ex_div_result  <= fix_result;
          ex_div_by_zero <= 1'b0;
        end

        DIV_ST_DONE: begin
          if (!pipe_stall) begin
            state          <= DIV_ST_IDLE;
            ex_div_done    <= 1'b0;
            ex_div_result  <= '0;
            ex_div_by_zero <= 1'b0;
          end
        end

        default: begin
          state <= DIV_ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_eco32f_div_ctrl.sv
// ============================================================================
// Module  : tb_eco32f_div_ctrl
// Purpose : Scoreboard bench for eco32f_div_ctrl. The driver pushes the
//           expected result, exception flag and latency of each issued op;
//           a monitor pops on each rising ex_div_done and compares.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_eco32f_div_ctrl;

  localparam int BPC  = 1;
  localparam int ITER = 32 / BPC;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_op_div = 1'b0;
  logic        ex_op_divu = 1'b0;
  logic        ex_op_rem = 1'b0;
  logic        ex_op_remu = 1'b0;
  logic [31:0] ex_x = '0;
  logic [31:0] ex_y = '0;
  logic        pipe_stall = 1'b0;
  logic        flush = 1'b0;
  logic        div_stall;
  logic        ex_div_done;
  logic [31:0] ex_div_result;
  logic        ex_div_by_zero;

  eco32f_div_ctrl #(.BITS_PER_CYCLE(BPC)) dut (
    .clk            (clk),
    .rst            (rst),
    .ex_valid       (ex_valid),
    .ex_op_div      (ex_op_div),
    .ex_op_divu     (ex_op_divu),
    .ex_op_rem      (ex_op_rem),
    .ex_op_remu     (ex_op_remu),
    .ex_x           (ex_x),
    .ex_y           (ex_y),
    .pipe_stall     (pipe_stall),
    .flush          (flush),
    .div_stall      (div_stall),
    .ex_div_done    (ex_div_done),
    .ex_div_result  (ex_div_result),
    .ex_div_by_zero (ex_div_by_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic        bz;
    int          lat;
    int          issue;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: kind 0=div 1=divu 2=rem 3=remu. Signed ops are done in
  // 64-bit arithmetic, which truncates toward zero and never overflows.
  function automatic exp_t model(input int kind, input logic [31:0] x, input logic [31:0] y);
    exp_t   m;
    longint sx, sy, ax, ay;
    bit     sgn;
    sgn   = (kind == 0) || (kind == 2);
    sx    = longint'($signed(x));
    sy    = longint'($signed(y));
    m.res = 32'd0;
    m.bz  = 1'b0;
    m.lat = ITER + 2;
    m.issue = 0;
    if (y == 32'd0) begin
      m.bz  = 1'b1;
      m.lat = 2;
    end else begin
      case (kind)
        0:       m.res = 32'(sx / sy);
        1:       m.res = x / y;
        2:       m.res = 32'(sx % sy);
        default: m.res = x % y;
      endcase
      ax = sgn ? (sx < 0 ? -sx : sx) : longint'({32'd0, x});
      ay = sgn ? (sy < 0 ? -sy : sy) : longint'({32'd0, y});
`ifdef ECO32F_DIV_EARLY_OUT_EN
      if (ax < ay) m.lat = 3;
`else
      if (ax < ay) m.lat = ITER + 2;
`endif
    end
    return m;
  endfunction

  task automatic set_op(input int kind, input logic v);
    ex_valid   = v;
    ex_op_div  = v && (kind == 0);
    ex_op_divu = v && (kind == 1);
    ex_op_rem  = v && (kind == 2);
    ex_op_remu = v && (kind == 3);
  endtask

  // Called at negedge+1; returns at negedge+1 with the instruction retired.
  task automatic do_op(input int kind, input logic [31:0] x, input logic [31:0] y, input int hold);
    exp_t e;
    int   n;
    e = model(kind, x, y);
    e.issue = cyc;
    sb.push_back(e);
    set_op(kind, 1'b1);
    ex_x = x;
    ex_y = y;
    pipe_stall = 1'($urandom_range(0, 1));
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
      if (n == 2) begin
        ex_x = $urandom;
        ex_y = $urandom;
      end
    end while (!ex_div_done && n < 200);
    if (!ex_div_done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: no ex_div_done within %0d cycles", n);
      if (sb.size() > 0) void'(sb.pop_back());
    end
    pipe_stall = 1'b1;
    repeat (hold) begin
      @(negedge clk); #1;
      check("done_held", {31'd0, ex_div_done}, 32'd1);
    end
    pipe_stall = 1'b0;
    @(negedge clk); #1;
    check("done_clear", {31'd0, ex_div_done}, 32'd0);
    check("result_clear", ex_div_result, 32'd0);
    check("bz_clear", {31'd0, ex_div_by_zero}, 32'd0);
    set_op(0, 1'b0);
  endtask

  task automatic do_flush(input int kind, input logic [31:0] x, input logic [31:0] y, input int at);
    set_op(kind, 1'b1);
    ex_x = x;
    ex_y = y;
    repeat (at) begin @(negedge clk); #1; end
    flush = 1'b1;
    @(negedge clk); #1;
    flush = 1'b0;
    set_op(0, 1'b0);
    check("flush_stall", {31'd0, div_stall}, 32'd0);
    check("flush_done", {31'd0, ex_div_done}, 32'd0);
    repeat (40) @(negedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 6))
      0:       return 32'd0;
      1:       return 32'($urandom_range(1, 20));
      2:       return 32'd0 - 32'($urandom_range(1, 20));
      3:       return 32'h8000_0000;
      4:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // ---------------------------------------------------------------- monitor
  initial begin
    exp_t cur;
    bit   have;
    int   stall_cnt;
    logic prev_done;
    have = 0;
    stall_cnt = 0;
    prev_done = 1'b0;
    cur = '{res: 32'd0, bz: 1'b0, lat: 0, issue: 0};
    forever begin
      @(negedge clk); #2;
      if (!rst) begin
        have = 0;
        stall_cnt = 0;
      end else if (ex_div_done && !prev_done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: result 0x%08h with no op outstanding", ex_div_result);
          have = 0;
        end else begin
          cur = sb.pop_front();
          have = 1;
          check("result", ex_div_result, cur.res);
          check("by_zero", {31'd0, ex_div_by_zero}, {31'd0, cur.bz});
          check("latency", 32'(cyc - cur.issue), 32'(cur.lat));
          check("stall_cycles", 32'(stall_cnt), 32'(cur.lat));
          check("stall_in_done", {31'd0, div_stall}, 32'd0);
        end
        stall_cnt = 0;
      end else if (ex_div_done && have) begin
        check("hold_result", ex_div_result, cur.res);
        check("hold_by_zero", {31'd0, ex_div_by_zero}, {31'd0, cur.bz});
      end else if (!ex_div_done && sb.size() > 0 && div_stall) begin
        stall_cnt++;
      end
      prev_done = ex_div_done;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    repeat (3) @(negedge clk);
    #1;
    check("rst_done", {31'd0, ex_div_done}, 32'd0);
    check("rst_result", ex_div_result, 32'd0);
    check("rst_bz", {31'd0, ex_div_by_zero}, 32'd0);
    check("rst_stall", {31'd0, div_stall}, 32'd0);
    rst = 1'b1;
    @(negedge clk); #1;

    // Non-divide instructions and bubbles never stall.
    ex_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ex_x = $urandom;
      ex_y = $urandom;
      #1 check("nondiv_stall", {31'd0, div_stall}, 32'd0);
      @(negedge clk); #1;
    end
    set_op(0, 1'b0);
    ex_op_div = 1'b1;
    #1 check("bubble_stall", {31'd0, div_stall}, 32'd0);
    @(negedge clk); #1;
    check("bubble_done", {31'd0, ex_div_done}, 32'd0);
    ex_op_div = 1'b0;

    // Directed cases; consecutive calls are back-to-back instructions.
    do_op(1, 32'd100, 32'd7, 0);
    do_op(3, 32'd100, 32'd7, 0);
    do_op(0, 32'hFFFF_FFF9, 32'd2, 1);
    do_op(2, 32'hFFFF_FFF9, 32'd2, 0);
    do_op(2, 32'd7, 32'hFFFF_FFFE, 0);
    do_op(0, 32'd5, 32'd0, 2);
    do_op(0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op(2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op(1, 32'hFFFF_FFFF, 32'd1, 0);
    do_op(1, 32'd3, 32'd9, 5);
    do_op(3, 32'd3, 32'd9, 0);
    do_op(0, 32'd0, 32'd13, 0);

    // Flush mid-iteration and flush on the issue cycle.
    do_flush(1, 32'd100, 32'd7, 10);
    do_flush(0, 32'd55, 32'd5, 0);
    do_op(3, 32'd1000, 32'd33, 0);

    // Asynchronous reset during BUSY.
    set_op(1, 1'b1);
    ex_x = 32'd12345;
    ex_y = 32'd67;
    repeat (12) begin @(negedge clk); #1; end
    check("busy_stall", {31'd0, div_stall}, 32'd1);
    rst = 1'b0;
    set_op(0, 1'b0);
    #1;
    check("arst_stall", {31'd0, div_stall}, 32'd0);
    check("arst_done", {31'd0, ex_div_done}, 32'd0);
    check("arst_result", ex_div_result, 32'd0);
    @(negedge clk); #1;
    rst = 1'b1;
    @(negedge clk); #1;
    do_op(0, 32'hFFFF_FF00, 32'd16, 0);

    // Randomized operations.
    for (int i = 0; i < 40; i++) begin
      do_op($urandom_range(0, 3), rand_val(), rand_val(), $urandom_range(0, 3));
    end

    repeat (4) @(negedge clk);
    #1;
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
